// File: rtl/mem_pkg.sv
// Shared memory-side definitions: word width, latency counter width and the
// request FSM state type used by main memory and the cache miss path.
package mem_pkg;
    localparam int WORD_W = 32;
    localparam int CNT_W  = 8;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_BUSY = 1'b1
    } mem_state_t;
endpackage

// File: rtl/mem_word_array.sv
// Single-port word storage: synchronous write, combinational read.
// Contents start at zero in simulation and are never touched by reset.
module mem_word_array
    import mem_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [WORD_W-1:0]    wdata,
    output logic [WORD_W-1:0]    rdata
);
    localparam int DEPTH = 1 << ADDR_BITS;

    logic [WORD_W-1:0] mem_q [DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];
endmodule

// File: rtl/main_mem_model.sv
// Fixed-latency main-memory model, one outstanding word request.
// Define MAIN_MEM_STATS_EN to add completed read/write counters (rd_count, wr_count).
module main_mem_model
    import mem_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              wr,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] data,
    output logic              response,
    output logic [WORD_W-1:0] out
`ifdef MAIN_MEM_STATS_EN
    ,
    output logic [WORD_W-1:0] rd_count,
    output logic [WORD_W-1:0] wr_count
`endif
);
    mem_state_t           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 wr_q, wr_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [WORD_W-1:0]    data_q, data_d;
    logic                 resp_q, resp_d;
    logic [WORD_W-1:0]    out_q, out_d;
    logic                 done;
    logic                 mem_we;
    logic [WORD_W-1:0]    rdata;
    logic                 addr_unused;

    assign addr_unused = &{1'b0, addr[WORD_W-1:ADDR_BITS]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        resp_d  = resp_q;
        out_d   = out_q;
        done    = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (req && resp_q) begin
                    state_d = MEM_BUSY;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    wr_d    = wr;
                    addr_d  = addr[ADDR_BITS-1:0];
                    data_d  = data;
                    resp_d  = 1'b0;
                end
            end
            MEM_BUSY: begin
                if (cnt_q == '0) begin
                    done    = 1'b1;
                    state_d = MEM_IDLE;
                    resp_d  = 1'b1;
                    if (!wr_q) begin
                        out_d = rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    // A reset landing on the completion edge must not commit the write.
    assign mem_we = done && wr_q && rst_n;

    mem_word_array #(
        .ADDR_BITS(ADDR_BITS)
    ) u_array (
        .clk  (clk),
        .we   (mem_we),
        .addr (addr_q),
        .wdata(data_q),
        .rdata(rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= MEM_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            resp_q  <= 1'b1;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            resp_q  <= resp_d;
            out_q   <= out_d;
        end
    end

    assign response = resp_q;
    assign out      = out_q;

`ifdef MAIN_MEM_STATS_EN
    logic [WORD_W-1:0] rd_count_q, rd_count_d;
    logic [WORD_W-1:0] wr_count_q, wr_count_d;

    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (done) begin
            if (wr_q) wr_count_d = wr_count_q + 1'b1;
            else      rd_count_d = rd_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif
endmodule

// File: tb/tb_main_mem_model.sv
// Directed bench: a LATENCY=4 instance for single ops and a LATENCY=1 instance
// for back-to-back traffic; MAIN_MEM_STATS_EN also checks the counters.
module tb_main_mem_model;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req4 = 1'b0;
    logic        req1 = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] data = '0;
    logic        resp4, resp1;
    logic [31:0] out4, out1;
`ifdef MAIN_MEM_STATS_EN
    logic [31:0] rdc4, wrc4, rdc1, wrc1;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    main_mem_model #(.ADDR_BITS(10), .LATENCY(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req(req4), .wr(wr), .addr(addr), .data(data),
        .response(resp4), .out(out4)
`ifdef MAIN_MEM_STATS_EN
        , .rd_count(rdc4), .wr_count(wrc4)
`endif
    );

    main_mem_model #(.ADDR_BITS(10), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .wr(wr), .addr(addr), .data(data),
        .response(resp1), .out(out1)
`ifdef MAIN_MEM_STATS_EN
        , .rd_count(rdc1), .wr_count(wrc1)
`endif
    );

    // Present one request to the LATENCY=4 instance; returns half a cycle after the acceptance edge.
    task automatic accept4(input logic w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        wr = w; addr = a; data = d; req4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req4 = 1'b0;
    endtask

    // Edges until response is seen high again; -1 if it never comes.
    task automatic wait_done4(output int n);
        bit seen;
        n = -1;
        seen = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (!seen) begin
                @(posedge clk);
                @(negedge clk);
                if (resp4) begin
                    n = i;
                    seen = 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (resp4 !== 1'b1 || resp1 !== 1'b1) begin
            fails++; $display("FAIL reset_response got %b/%b want 1/1", resp4, resp1);
        end
        tests++;
        if (out4 !== 32'h0 || out1 !== 32'h0) begin
            fails++; $display("FAIL reset_out got %h/%h want 0/0", out4, out1);
        end
`ifdef MAIN_MEM_STATS_EN
        tests++;
        if (rdc4 !== 0 || wrc4 !== 0 || rdc1 !== 0 || wrc1 !== 0) begin
            fails++; $display("FAIL reset_stats got %0d %0d %0d %0d want 0", rdc4, wrc4, rdc1, wrc1);
        end
`endif
        rst_n = 1'b1;
        accept4(1'b0, 32'h0, 32'h0);
        tests++;
        if (resp4 !== 1'b0) begin
            fails++; $display("FAIL first_accept response got %b want 0", resp4);
        end
        wait_done4(n);
        tests++;
        if (n !== 4 || out4 !== 32'h0) begin
            fails++; $display("FAIL first_read edges %0d out %h want 4 / 0", n, out4);
        end
    endtask

    task automatic test_write_read();
        int n;
        accept4(1'b1, 32'h10, 32'hDEADBEEF);
        wait_done4(n);
        tests++;
        if (n !== 4) begin
            fails++; $display("FAIL write_latency got %0d edges want 4", n);
        end
        tests++;
        if (out4 !== 32'h0) begin
            fails++; $display("FAIL write_keeps_out got %h want 0", out4);
        end
        accept4(1'b0, 32'h10, 32'h0);
        wait_done4(n);
        tests++;
        if (n !== 4 || out4 !== 32'hDEADBEEF) begin
            fails++; $display("FAIL read_after_write edges %0d out %h want 4 / deadbeef", n, out4);
        end
    endtask

    task automatic test_wrap();
        int n;
        accept4(1'b1, (32'd1 << 10) + 32'd3, 32'h12345678);
        wait_done4(n);
        accept4(1'b0, 32'h3, 32'h0);
        wait_done4(n);
        tests++;
        if (out4 !== 32'h12345678) begin
            fails++; $display("FAIL addr_wrap got %h want 12345678", out4);
        end
    endtask

    task automatic test_busy_ignore();
        int n;
        accept4(1'b0, 32'h20, 32'h0);
        @(posedge clk);
        @(negedge clk);
        wr = 1'b1; addr = 32'h20; data = 32'h1; req4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req4 = 1'b0; wr = 1'b0; addr = 32'h0;
        wait_done4(n);
        tests++;
        if (n !== 2 || out4 !== 32'h0) begin
            fails++; $display("FAIL busy_read edges %0d out %h want 2 / 0", n, out4);
        end
        accept4(1'b0, 32'h20, 32'h0);
        wait_done4(n);
        tests++;
        if (out4 !== 32'h0) begin
            fails++; $display("FAIL busy_ignore got %h want 0", out4);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        accept4(1'b0, 32'h10, 32'h0);
        wait_done4(n);
        tests++;
        if (out4 !== 32'hDEADBEEF) begin
            fails++; $display("FAIL preload_out got %h want deadbeef", out4);
        end
        accept4(1'b1, 32'h30, 32'hA5A5A5A5);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tests++;
        if (resp4 !== 1'b1 || out4 !== 32'h0) begin
            fails++; $display("FAIL mid_reset resp %b out %h want 1 / 0", resp4, out4);
        end
`ifdef MAIN_MEM_STATS_EN
        tests++;
        if (wrc4 !== 0) begin
            fails++; $display("FAIL mid_reset_wr_count got %0d want 0", wrc4);
        end
`endif
        accept4(1'b0, 32'h30, 32'h0);
        wait_done4(n);
        tests++;
        if (out4 !== 32'h0) begin
            fails++; $display("FAIL aborted_write got %h want 0", out4);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3] = '{32'h11111111, 32'h22222222, 32'h33333333};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            wr = 1'b1; addr = 32'(k + 1); data = vals[k]; req1 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            req1 = 1'b0;
            tests++;
            if (resp1 !== 1'b0) begin
                fails++; $display("FAIL lat1_write%0d busy got %b want 0", k, resp1);
            end
            @(posedge clk);
            @(negedge clk);
            tests++;
            if (resp1 !== 1'b1) begin
                fails++; $display("FAIL lat1_write%0d done got %b want 1", k, resp1);
            end
        end
        @(negedge clk);
        wr = 1'b0; addr = 32'h1; req1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            tests++;
            if (resp1 !== 1'b0) begin
                fails++; $display("FAIL b2b_accept%0d response got %b want 0", k, resp1);
            end
            addr = 32'(k + 2);
            @(posedge clk);
            @(negedge clk);
            if (k == 2) req1 = 1'b0;
            tests++;
            if (resp1 !== 1'b1 || out1 !== vals[k]) begin
                fails++; $display("FAIL b2b_read%0d resp %b out %h want 1 / %h", k, resp1, out1, vals[k]);
            end
        end
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (resp1 !== 1'b1) begin
            fails++; $display("FAIL b2b_idle response got %b want 1", resp1);
        end
`ifdef MAIN_MEM_STATS_EN
        tests++;
        if (rdc1 !== 3 || wrc1 !== 3) begin
            fails++; $display("FAIL b2b_stats rd %0d wr %0d want 3 / 3", rdc1, wrc1);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wrap();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d tests", tests);
        $fatal(1, "timeout");
    end
endmodule
